// File: rtl/bloons_vga_pkg.sv
// Shared 640x480@60 VGA geometry and coordinate type used by the scanner and every renderer.
package bloons_vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_END   = 751;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_V_VISIBLE    = 480;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_END   = 491;
    localparam int VGA_V_TOTAL      = 525;

    function automatic coord_t to_coord(input int value);
        return coord_t'(value);
    endfunction

endpackage

// File: rtl/sprite_scanner_if.sv
// Bundle between the sprite scanner and its renderer; mirror exists only with SPRITE_MIRROR_EN.
interface sprite_scanner_if;
    import bloons_vga_pkg::*;

    coord_t SpriteX;
    coord_t SpriteY;
`ifdef SPRITE_MIRROR_EN
    logic   mirror;
`endif
    logic   hs;
    logic   vs;
    logic   blank;
    coord_t DrawX;
    coord_t DrawY;
    coord_t RelativeX;
    coord_t RelativeY;
    logic   sprite_hit;
    logic   sprite_hit_d;
    logic   frame_start;

    modport master (
        input  SpriteX, SpriteY,
`ifdef SPRITE_MIRROR_EN
        input  mirror,
`endif
        output hs, vs, blank, DrawX, DrawY, RelativeX, RelativeY,
        output sprite_hit, sprite_hit_d, frame_start
    );

    modport slave (
        output SpriteX, SpriteY,
`ifdef SPRITE_MIRROR_EN
        output mirror,
`endif
        input  hs, vs, blank, DrawX, DrawY, RelativeX, RelativeY,
        input  sprite_hit, sprite_hit_d, frame_start
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with registered sync, blank and frame_start, all aligned to the counters.
module vga_timing_gen
    import bloons_vga_pkg::*;
#(
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_END   = VGA_H_SYNC_END,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_END   = VGA_V_SYNC_END,
    parameter int V_TOTAL      = VGA_V_TOTAL
) (
    input  logic   vga_clk,
    input  logic   reset_n,
    output coord_t draw_x,
    output coord_t draw_y,
    output logic   hs,
    output logic   vs,
    output logic   blank,
    output logic   frame_start
);

    localparam coord_t H_LAST = to_coord(H_TOTAL - 1);
    localparam coord_t V_LAST = to_coord(V_TOTAL - 1);
    localparam coord_t H_VIS  = to_coord(H_VISIBLE);
    localparam coord_t V_VIS  = to_coord(V_VISIBLE);
    localparam coord_t H_SS   = to_coord(H_SYNC_START);
    localparam coord_t H_SE   = to_coord(H_SYNC_END);
    localparam coord_t V_SS   = to_coord(V_SYNC_START);
    localparam coord_t V_SE   = to_coord(V_SYNC_END);

    coord_t next_x;
    coord_t next_y;

    always_comb begin
        next_x = draw_x + 10'd1;
        next_y = draw_y;
        if (draw_x == H_LAST) begin
            next_x = '0;
            next_y = (draw_y == V_LAST) ? '0 : draw_y + 10'd1;
        end
    end

    // Decoding the next position keeps sync/blank in the same cycle as the counters they describe.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x      <= '0;
            draw_y      <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            draw_x      <= next_x;
            draw_y      <= next_y;
            hs          <= !((next_x >= H_SS) && (next_x <= H_SE));
            vs          <= !((next_y >= V_SS) && (next_y <= V_SE));
            blank       <= (next_x < H_VIS) && (next_y < V_VIS);
            frame_start <= (next_x == '0) && (next_y == '0);
        end
    end

endmodule

// File: rtl/sprite_scanner.sv
// VGA scanner with a frame-latched sprite box, hit/offset outputs and a hit delay line.
// Optional horizontal mirroring is enabled with the SPRITE_MIRROR_EN macro.
module sprite_scanner
    import bloons_vga_pkg::*;
#(
    parameter int SPRITE_W     = 32,
    parameter int PIPE_DLY     = 2,
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_END   = VGA_H_SYNC_END,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_END   = VGA_V_SYNC_END,
    parameter int V_TOTAL      = VGA_V_TOTAL
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    sprite_scanner_if.master bus
);

    localparam coord_t      LATCH_ROW = to_coord(V_VISIBLE);
    localparam coord_t      LAST_OFF  = to_coord(SPRITE_W - 1);
    localparam logic [10:0] SPAN      = 11'(SPRITE_W);

    coord_t              draw_x;
    coord_t              draw_y;
    logic                blank;
    coord_t              latched_x;
    coord_t              latched_y;
    logic                active;
    logic [10:0]         dx;
    logic [10:0]         dy;
    logic                hit;
    coord_t              off_x;
    logic [PIPE_DLY-1:0] dly;
`ifdef SPRITE_MIRROR_EN
    logic                latched_mirror;
`endif

    vga_timing_gen #(
        .H_VISIBLE   (H_VISIBLE),
        .H_SYNC_START(H_SYNC_START),
        .H_SYNC_END  (H_SYNC_END),
        .H_TOTAL     (H_TOTAL),
        .V_VISIBLE   (V_VISIBLE),
        .V_SYNC_START(V_SYNC_START),
        .V_SYNC_END  (V_SYNC_END),
        .V_TOTAL     (V_TOTAL)
    ) u_timing (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .hs         (bus.hs),
        .vs         (bus.vs),
        .blank      (blank),
        .frame_start(bus.frame_start)
    );

    // Position is only picked up at the start of vertical blanking so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            latched_x <= '0;
            latched_y <= '0;
`ifdef SPRITE_MIRROR_EN
            latched_mirror <= 1'b0;
`endif
        end else if ((draw_x == '0) && (draw_y == LATCH_ROW)) begin
            latched_x <= bus.SpriteX;
            latched_y <= bus.SpriteY;
`ifdef SPRITE_MIRROR_EN
            latched_mirror <= bus.mirror;
`endif
        end
    end

    // The reset-time (0,0) pixel would otherwise hit the reset-latched box at (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_comb begin
        dx  = {1'b0, draw_x} - {1'b0, latched_x};
        dy  = {1'b0, draw_y} - {1'b0, latched_y};
        hit = active && blank && (dx < SPAN) && (dy < SPAN);
`ifdef SPRITE_MIRROR_EN
        off_x = latched_mirror ? (LAST_OFF - dx[9:0]) : dx[9:0];
`else
        off_x = dx[9:0];
`endif
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
        end else begin
            dly[0] <= hit;
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign bus.DrawX        = draw_x;
    assign bus.DrawY        = draw_y;
    assign bus.blank        = blank;
    assign bus.sprite_hit   = hit;
    assign bus.RelativeX    = hit ? off_x : '0;
    assign bus.RelativeY    = hit ? dy[9:0] : '0;
    assign bus.sprite_hit_d = dly[PIPE_DLY-1];

endmodule

// File: tb/tb_sprite_scanner.sv
// Self-checking bench for sprite_scanner on a reduced raster, compared cycle by cycle to a frame model.
module tb_sprite_scanner;
    import bloons_vga_pkg::*;

    localparam int SW  = 8;
    localparam int PD  = 2;
    localparam int HV  = 40;
    localparam int HSS = 44;
    localparam int HSE = 49;
    localparam int HT  = 56;
    localparam int VV  = 30;
    localparam int VSS = 32;
    localparam int VSE = 33;
    localparam int VT  = 36;
    localparam int FRAME = HT * VT;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    int t     = 0;
    int m_lx  = 0;
    int m_ly  = 0;
    int m_mir = 0;
    int hit_hist[$];

    int fs_seen  = 0;
    int hs_low   = 0;
    int vs_low   = 0;

    always #20 vga_clk = ~vga_clk;

    sprite_scanner_if bus();

    sprite_scanner #(
        .SPRITE_W    (SW),
        .PIPE_DLY    (PD),
        .H_VISIBLE   (HV),
        .H_SYNC_START(HSS),
        .H_SYNC_END  (HSE),
        .H_TOTAL     (HT),
        .V_VISIBLE   (VV),
        .V_SYNC_START(VSS),
        .V_SYNC_END  (VSE),
        .V_TOTAL     (VT)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic check_value(input string tag, input int observed, input int expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d (t=%0d)", tag, observed, expected, t);
        end
    endtask

    // Box membership with plain signed arithmetic: off-screen parts simply never match.
    function automatic bit model_hit(input int tt);
        int x  = tt % HT;
        int y  = (tt / HT) % VT;
        int ox = x - m_lx;
        int oy = y - m_ly;
        if (tt == 0) return 1'b0;
        return (x < HV) && (y < VV) && (ox >= 0) && (ox < SW) && (oy >= 0) && (oy < SW);
    endfunction

    task automatic reset_model();
        t     = 0;
        m_lx  = 0;
        m_ly  = 0;
        m_mir = 0;
        hit_hist.delete();
        for (int i = 0; i < PD; i++) hit_hist.push_back(0);
    endtask

    task automatic advance_model();
        int x = t % HT;
        int y = (t / HT) % VT;
        hit_hist.push_back(int'(model_hit(t)));
        void'(hit_hist.pop_front());
        if ((x == 0) && (y == VV)) begin
            m_lx = int'(bus.SpriteX);
            m_ly = int'(bus.SpriteY);
`ifdef SPRITE_MIRROR_EN
            m_mir = int'(bus.mirror);
`endif
        end
        t++;
    endtask

    task automatic applyStimulus(input int sx, input int sy);
        bus.SpriteX = coord_t'(sx);
        bus.SpriteY = coord_t'(sy);
    endtask

    task automatic random_stimulus();
        int sx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, HV + SW));
        int sy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, VV + SW));
        applyStimulus(sx, sy);
`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic checkOutput();
        int x   = t % HT;
        int y   = (t / HT) % VT;
        bit h   = model_hit(t);
        int ox  = x - m_lx;
        int oy  = y - m_ly;
        int erx = h ? ((m_mir != 0) ? (SW - 1 - ox) : ox) : 0;
        int ery = h ? oy : 0;
        check_value("DrawX", int'(bus.DrawX), x);
        check_value("DrawY", int'(bus.DrawY), y);
        check_value("hs", int'(bus.hs), (x >= HSS && x <= HSE) ? 0 : 1);
        check_value("vs", int'(bus.vs), (y >= VSS && y <= VSE) ? 0 : 1);
        check_value("blank", int'(bus.blank), (x < HV && y < VV) ? 1 : 0);
        check_value("sprite_hit", int'(bus.sprite_hit), int'(h));
        check_value("RelativeX", int'(bus.RelativeX), erx);
        check_value("RelativeY", int'(bus.RelativeY), ery);
        check_value("sprite_hit_d", int'(bus.sprite_hit_d), hit_hist[0]);
        check_value("frame_start", int'(bus.frame_start), (t > 0 && x == 0 && y == 0) ? 1 : 0);
        if (bus.frame_start === 1'b1) fs_seen++;
        if (bus.hs === 1'b0) hs_low++;
        if (bus.vs === 1'b0) vs_low++;
    endtask

    task automatic check_reset(input string tag);
        check_value({tag, "_DrawX"}, int'(bus.DrawX), 0);
        check_value({tag, "_DrawY"}, int'(bus.DrawY), 0);
        check_value({tag, "_hs"}, int'(bus.hs), 1);
        check_value({tag, "_vs"}, int'(bus.vs), 1);
        check_value({tag, "_blank"}, int'(bus.blank), 1);
        check_value({tag, "_sprite_hit"}, int'(bus.sprite_hit), 0);
        check_value({tag, "_sprite_hit_d"}, int'(bus.sprite_hit_d), 0);
        check_value({tag, "_RelativeX"}, int'(bus.RelativeX), 0);
        check_value({tag, "_RelativeY"}, int'(bus.RelativeY), 0);
        check_value({tag, "_frame_start"}, int'(bus.frame_start), 0);
    endtask

    task automatic step_cycle();
        @(posedge vga_clk);
        advance_model();
        @(negedge vga_clk);
        checkOutput();
    endtask

    task automatic run_cycles(input int n, input bit randomize);
        for (int i = 0; i < n; i++) begin
            if (randomize) random_stimulus();
            step_cycle();
        end
    endtask

    task automatic run_to_pos(input int tx, input int ty);
        int guard = 0;
        while (!(((t % HT) == tx) && (((t / HT) % VT) == ty)) && (guard < FRAME)) begin
            step_cycle();
            guard++;
        end
    endtask

    initial begin
        reset_model();
        applyStimulus(0, 0);
`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        $display("[TB] checking reset state");
        check_reset("reset");
        reset_n = 1'b1;

        // First frame: box from the reset latch, then the new position is picked up at row VV.
        applyStimulus(10, 5);
        fs_seen = 0;
        hs_low  = 0;
        vs_low  = 0;
        run_cycles(FRAME, 1'b0);
        check_value("frame_start_per_frame", fs_seen, 1);
        check_value("hs_low_cycles_per_frame", hs_low, (HSE - HSS + 1) * VT);
        check_value("vs_low_cycles_per_frame", vs_low, (VSE - VSS + 1) * HT);

        // Mid-frame position change must not move the box until the next latch.
        $display("[TB] mid-frame position change");
        run_to_pos(0, 12);
        applyStimulus(25, 5);
        run_cycles(FRAME, 1'b0);

        $display("[TB] bottom-right clipping");
        applyStimulus(HV - 4, VV - 3);
        run_cycles(2 * FRAME, 1'b0);

        $display("[TB] randomized positions");
        run_cycles(6 * FRAME, 1'b1);

        $display("[TB] asynchronous reset mid-line");
        applyStimulus(3, 2);
`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'b0;
`endif
        run_to_pos(17, 4);
        #5 reset_n = 1'b0;
        #1 check_reset("async_reset");
        reset_model();
        @(negedge vga_clk);
        reset_n = 1'b1;
        run_cycles(FRAME + HT, 1'b0);

`ifdef SPRITE_MIRROR_EN
        $display("[TB] mirrored sprite");
        bus.mirror = 1'b1;
        applyStimulus(10, 5);
        run_cycles(2 * FRAME, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
